// File: rtl/sensor_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sensor_scan_ctrl_pkg
// Shared definitions for the baggage-drop height acquisition controller:
//   - 2-bit FSM state encodings (IDLE, SETTLE, REQ, CALC)
//   - front-end channel indices for sensor1..sensor4
//   - default data width, settle and timeout cycle counts
// No ports (package).
// -----------------------------------------------------------------------------
package sensor_scan_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_REQ    = 2'd2;
    localparam logic [1:0] ST_CALC   = 2'd3;

    // Front-end channel select values
    localparam logic [1:0] CH_SENSOR1 = 2'd0;
    localparam logic [1:0] CH_SENSOR2 = 2'd1;
    localparam logic [1:0] CH_SENSOR3 = 2'd2;
    localparam logic [1:0] CH_SENSOR4 = 2'd3;

    // Defaults
    localparam int unsigned DEF_DATA_W         = 8;
    localparam int unsigned DEF_SETTLE_CYCLES  = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/sensor_scan_ctrl_height_calc.sv
// -----------------------------------------------------------------------------
// height_calc
// Combinational height computation from four stored sensor readings using the
// faulty-sensor pairing rule with round-half-up averaging. A reading of 0 is
// treated as invalid.
// Ports:
//   i_r1..i_r4 : DATA_W-bit readings of sensor1..sensor4
//   o_height   : DATA_W-bit computed height
// -----------------------------------------------------------------------------
module height_calc #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_r1,
    input  logic [DATA_W-1:0] i_r2,
    input  logic [DATA_W-1:0] i_r3,
    input  logic [DATA_W-1:0] i_r4,
    output logic [DATA_W-1:0] o_height
);

    logic [DATA_W:0]   w_sum2;
    logic [DATA_W+1:0] w_sum4;
    logic              w_use_pair;

    always_comb begin
        w_sum2     = '0;
        w_sum4     = '0;
        w_use_pair = 1'b1;
        o_height   = '0;

        // A bad sensor in the r1/r3 pair falls back to r2/r4 and vice versa
        if ((i_r1 == '0) || (i_r3 == '0)) begin
            w_sum2 = {1'b0, i_r2} + {1'b0, i_r4};
        end else if ((i_r2 == '0) || (i_r4 == '0)) begin
            w_sum2 = {1'b0, i_r1} + {1'b0, i_r3};
        end else begin
            w_use_pair = 1'b0;
            w_sum4 = {2'b00, i_r1} + {2'b00, i_r2} + {2'b00, i_r3} + {2'b00, i_r4};
        end

        // Round half up: add back the highest bit shifted out
        if (w_use_pair) begin
            if (w_sum2 != '0) begin
                o_height = w_sum2[DATA_W:1] + {{(DATA_W-1){1'b0}}, w_sum2[0]};
            end
        end else if (w_sum4 != '0) begin
            o_height = w_sum4[DATA_W+1:2] + {{(DATA_W-1){1'b0}}, w_sum4[1]};
        end
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sensor_scan_ctrl
// Sequential acquisition controller: on start, polls four height sensors one at
// a time through a shared front-end (select / settle / request / ack), records
// timeouts as faults, then presents a registered height with a one-cycle valid.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : scan request, sampled only when idle
//   sensor_sel    : front-end channel select (0..3 = sensor1..sensor4)
//   sample_req    : sample request to the front-end
//   sample_ack    : front-end sample_data valid this cycle
//   sample_data   : reading for the selected channel
//   height        : last computed height, held until the next result
//   height_valid  : one-cycle strobe when height updates
//   busy          : high whenever a scan is in progress
//   fault         : bit i set if sensor i+1 timed out in the last scan
// -----------------------------------------------------------------------------
module sensor_scan_ctrl
    import sensor_scan_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [1:0]        sensor_sel,
    output logic              sample_req,
    input  logic              sample_ack,
    input  logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] height,
    output logic              height_valid,
    output logic              busy,
    output logic [3:0]        fault
);

    // One counter serves both SETTLE and REQ; it is cleared on every state change
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_reading [4];
    logic [3:0]        r_fault_pend;
    logic [3:0]        r_fault;
    logic [DATA_W-1:0] r_height;
    logic              r_height_valid;

    logic              w_timeout;
    logic [DATA_W-1:0] w_height;

    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    height_calc #(
        .DATA_W (DATA_W)
    ) u_height_calc (
        .i_r1     (r_reading[0]),
        .i_r2     (r_reading[1]),
        .i_r3     (r_reading[2]),
        .i_r4     (r_reading[3]),
        .o_height (w_height)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_sel          <= CH_SENSOR1;
            r_cnt          <= '0;
            r_fault_pend   <= '0;
            r_fault        <= '0;
            r_height       <= '0;
            r_height_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_reading[i] <= '0;
            end
        end else begin
            r_height_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sel        <= CH_SENSOR1;
                    r_cnt        <= '0;
                    r_fault_pend <= '0;
                    if (start) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    // Ack wins over a simultaneous timeout
                    if (sample_ack || w_timeout) begin
                        r_reading[r_sel] <= sample_ack ? sample_data : '0;
                        if (!sample_ack) begin
                            r_fault_pend[r_sel] <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_sel == CH_SENSOR4) begin
                            r_state <= ST_CALC;
                        end else begin
                            r_sel   <= r_sel + 2'd1;
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CALC: begin
                    r_height       <= w_height;
                    r_fault        <= r_fault_pend;
                    r_height_valid <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // State decodes only; no input reaches an output without a register
    assign sensor_sel   = r_sel;
    assign sample_req   = (r_state == ST_REQ);
    assign busy         = (r_state != ST_IDLE);
    assign height       = r_height;
    assign height_valid = r_height_valid;
    assign fault        = r_fault;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sensor_scan_ctrl
// Directed bench for sensor_scan_ctrl with a front-end responder, an arithmetic
// reference model of the height rule and a per-cycle output comparator.
// -----------------------------------------------------------------------------
module tb_sensor_scan_ctrl;

    localparam int S = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sample_ack = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic [1:0] sensor_sel;
    logic       sample_req;
    logic [7:0] height;
    logic       height_valid;
    logic       busy;
    logic [3:0] fault;

    int checks = 0;
    int failures = 0;

    // Front-end behaviour per channel: value and REQ cycle (1-based) of the ack; 0 = never
    int tb_val [4];
    int tb_ack [4];
    int run_len [4];
    bit stray_en = 1'b0;

    typedef struct { int h; int f; } exp_t;
    exp_t exp_q [$];
    int last_h = 0;
    int last_f = 0;

    sensor_scan_ctrl #(
        .DATA_W         (8),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sensor_sel   (sensor_sel),
        .sample_req   (sample_req),
        .sample_ack   (sample_ack),
        .sample_data  (sample_data),
        .height       (height),
        .height_valid (height_valid),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit acked(input int i);
        return (tb_ack[i] >= 1) && (tb_ack[i] <= T);
    endfunction

    function automatic int reading(input int i);
        return acked(i) ? tb_val[i] : 0;
    endfunction

    function automatic int model_fault();
        int f = 0;
        for (int i = 0; i < 4; i++) if (!acked(i)) f += (1 << i);
        return f;
    endfunction

    // Rounded mean of the usable readings: pair average or four-way average
    function automatic int model_height();
        int r1 = reading(0);
        int r2 = reading(1);
        int r3 = reading(2);
        int r4 = reading(3);
        if (r1 == 0 || r3 == 0) return (r2 + r4 + 1) / 2;
        if (r2 == 0 || r4 == 0) return (r1 + r3 + 1) / 2;
        return (r1 + r2 + r3 + r4 + 2) / 4;
    endfunction

    function automatic int model_latency();
        int l = 1;
        for (int i = 0; i < 4; i++) l += S + (acked(i) ? tb_ack[i] : T);
        return l;
    endfunction

    task automatic set_tab(input int v0, input int v1, input int v2, input int v3,
                           input int a0, input int a1, input int a2, input int a3);
        tb_val[0] = v0; tb_val[1] = v1; tb_val[2] = v2; tb_val[3] = v3;
        tb_ack[0] = a0; tb_ack[1] = a1; tb_ack[2] = a2; tb_ack[3] = a3;
    endtask

    // Front-end responder
    initial begin
        int run;
        int sel;
        run = 0;
        sel = 0;
        forever begin
            @(negedge clk);
            if (sample_req) begin
                if (run > 0) chk("sel_stable", int'(sensor_sel), sel);
                sel = int'(sensor_sel);
                run++;
                run_len[sel] = run;
                if (run == tb_ack[sel]) begin
                    sample_ack  = 1'b1;
                    sample_data = 8'(tb_val[sel]);
                end else begin
                    sample_ack  = 1'b0;
                    sample_data = 8'hA5;
                end
            end else begin
                run = 0;
                sample_ack  = stray_en && busy;
                sample_data = 8'hEE;
            end
        end
    end

    // Per-cycle comparator against the model's expected results
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                last_h = 0;
                last_f = 0;
            end else begin
                if (height_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        last_h = e.h;
                        last_f = e.f;
                    end
                end
                chk("height_model", int'(height), last_h);
                chk("fault_model", int'(fault), last_f);
                chk("req_implies_busy", int'(sample_req && !busy), 0);
            end
        end
    end

    task automatic do_scan(input string tag, input int lit_h, input int lit_f, input bit mid_start);
        int n;
        exp_t e;
        for (int i = 0; i < 4; i++) run_len[i] = 0;
        e.h = model_height();
        e.f = model_fault();
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!height_valid && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = mid_start && (n == 8);
        end
        start = 1'b0;
        chk({tag, "_valid_seen"}, int'(height_valid), 1);
        chk({tag, "_latency"}, n, model_latency());
        chk({tag, "_height"}, int'(height), lit_h);
        chk({tag, "_fault"}, int'(fault), lit_f);
        chk({tag, "_busy_at_valid"}, int'(busy), 0);
        for (int i = 0; i < 4; i++)
            chk({tag, "_req_len"}, run_len[i], acked(i) ? tb_ack[i] : T);
        @(negedge clk);
        chk({tag, "_valid_one_cycle"}, int'(height_valid), 0);
        chk({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int v [3];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sensor_sel", int'(sensor_sel), 0);
        chk("rst_sample_req", int'(sample_req), 0);
        chk("rst_height", int'(height), 0);
        chk("rst_height_valid", int'(height_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault", int'(fault), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // All valid
        set_tab(10, 11, 12, 13, 1, 1, 1, 1);
        do_scan("all_valid", 12, 0, 1'b0);

        // Invalid sensor in a pair, with some delayed acks
        set_tab(0, 7, 9, 8, 1, 3, 1, 2);
        do_scan("r1_zero", 8, 0, 1'b0);
        set_tab(30, 0, 31, 99, 1, 1, 1, 1);
        do_scan("r2_zero", 31, 0, 1'b0);

        // Sensor3 timeout, then ack exactly on the last REQ cycle
        set_tab(50, 60, 99, 70, 1, 1, 0, 1);
        do_scan("timeout", 65, 4, 1'b0);
        set_tab(50, 60, 70, 70, 1, 1, T, 1);
        do_scan("ack_at_limit", 63, 0, 1'b0);

        // Extremes
        set_tab(255, 255, 255, 254, 1, 1, 1, 1);
        do_scan("max", 255, 0, 1'b0);
        set_tab(0, 0, 0, 0, 1, 1, 1, 1);
        do_scan("zeros", 0, 0, 1'b0);

        // Start mid-scan and stray acks outside REQ are ignored
        stray_en = 1'b1;
        set_tab(10, 20, 30, 40, 1, 1, 1, 1);
        do_scan("midstart", 25, 0, 1'b1);
        stray_en = 1'b0;

        // Reset while waiting in REQ on sensor2
        set_tab(10, 20, 30, 40, 1, 0, 1, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(sample_req && sensor_sel == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_req", int'(sample_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_sample_req", int'(sample_req), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_sensor_sel", int'(sensor_sel), 0);
        chk("rst_mid_height", int'(height), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        set_tab(10, 11, 12, 13, 1, 1, 1, 1);
        do_scan("after_rst", 12, 0, 1'b0);

        // Back-to-back scans with start held high
        set_tab(1, 2, 3, 4, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) exp_q.push_back('{h: 3, f: 0});
        @(negedge clk);
        start = 1'b1;
        n = 0;
        k = 0;
        while (k < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (height_valid) begin
                v[k] = n;
                k++;
            end
        end
        start = 1'b0;
        chk("b2b_count", k, 3);
        if (k == 3) begin
            chk("b2b_first", v[0], 22);
            chk("b2b_period1", v[1] - v[0], 22);
            chk("b2b_period2", v[2] - v[1], 22);
        end
        chk("b2b_height", int'(height), 3);
        repeat (3) @(negedge clk);
        chk("b2b_stopped", int'(busy), 0);
        chk("expect_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_scan_ctrl.md
# sensor_scan_ctrl

Sequential acquisition controller for the baggage-drop height path. On a start pulse it polls the four height sensors, one at a time, through a shared single-channel sensor front-end using a select/request/acknowledge handshake. It applies the faulty-sensor pairing rule with round-half-up averaging and presents a registered height with a one-cycle valid strobe to the drop logic.

## Interface

- `DATA_W`, 8: sensor sample and height width.
- `SETTLE_CYCLES`, 4: cycles to wait after changing `sensor_sel` before requesting a sample. Legal range is 1 or more.
- `TIMEOUT_CYCLES`, 16: maximum request cycles to wait for `sample_ack`. Legal range is 1 or more.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: scan request pulse. Sampled only in IDLE.
- `sensor_sel` out 2: front-end channel select. 0 to 3 map to sensor1 to sensor4.
- `sample_req` out 1: sample request to the front-end.
- `sample_ack` in 1: front-end has valid `sample_data` this cycle.
- `sample_data` in DATA_W: reading for the selected channel.
- `height` out DATA_W: last computed height. Held until the next result.
- `height_valid` out 1: one-cycle strobe when `height` updates.
- `busy` out 1: high in every state except IDLE.
- `fault` out 4: bit i is set if sensor i+1 timed out in the last scan. Updated together with `height`.

## Operation

- **States:** IDLE, SETTLE, REQ, CALC.
- **IDLE:**
  - `start`=1 moves to SETTLE.
  - Clears `sensor_sel`, the settle counter and the pending fault bits.
- **SETTLE:**
  - `sample_req`=0.
  - Counts SETTLE_CYCLES cycles, then moves to REQ.
- **REQ:**
  - `sample_req`=1.
  - `sample_ack`=1 stores `sample_data` into reading[`sensor_sel`].
  - Otherwise, on the TIMEOUT_CYCLES-th REQ cycle, stores 0 into reading[`sensor_sel`] and sets pending fault[`sensor_sel`].
  - If ack and timeout occur in the same cycle, the ack wins and no fault is recorded.
  - After the store: if `sensor_sel`=3, go to CALC; otherwise increment `sensor_sel` and go to SETTLE.
- **CALC:**
  - Registers `height` and `fault`, pulses `height_valid`, then returns to IDLE.
- **Height rule:** r1 to r4 are the stored readings, and a reading of 0 means invalid.
  - If r1=0 or r3=0: sum2 = r2+r4, computed 9 bits wide.
  - Else if r2=0 or r4=0: sum2 = r1+r3.
  - Else: sum4 = r1+r2+r3+r4, computed 10 bits wide.
  - For a nonzero sum2: height = (sum2>>1) + sum2[0].
  - Otherwise, for a nonzero sum4: height = (sum4>>2) + sum4[1].
  - Otherwise height = 0.
  - The result never exceeds 255, so no saturation is needed.
- **Ignored inputs:**
  - `start` while `busy` is ignored, with no queuing.
  - `sample_ack` outside REQ is ignored.
- **Reset:** asserting `rst_n` low at any time, including mid-scan, returns to IDLE.

## Timing

- **Reset values:**
  - `sensor_sel`=0, `sample_req`=0, `height`=0, `height_valid`=0, `busy`=0, `fault`=0.
  - All readings cleared.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Latency:**
  - Edge E samples `start`. With ack in the first REQ cycle of every sensor, `height_valid` is high after edge E + 4·(SETTLE_CYCLES+1) + 1.
  - With the defaults this is 21 edges.
  - Each sensor timeout adds TIMEOUT_CYCLES−1 cycles.
- **Request/ack handshake:**
  - `sample_req` stays high continuously from entering REQ until the capturing edge, then drops in the next cycle.
  - `sensor_sel` is stable for the whole SETTLE and REQ period of a channel.
- **Back-to-back scans:** `start` is accepted the cycle after CALC. This is the same cycle in which `height_valid` is high.

## Structure

- **Shared header:**
  - State encodings (2-bit).
  - Channel index constants for sensor1 to sensor4.
  - Default SETTLE_CYCLES and TIMEOUT_CYCLES.
- **Sub-module `height_calc`:** combinational. It takes four DATA_W readings and outputs DATA_W height, implementing the pairing and rounding rule. The FSM, counters and reading registers live in `sensor_scan_ctrl`.

## Test plan

- **All valid:** acks with 10, 11, 12, 13 → height=12 (46>>2=11, plus bit1), fault=0000, latency 21 edges.
- **Sensor1 zero:** readings 0, 7, 9, 8 → height=8 (15→7+1). Readings 30, 0, 31, 99 → height=31 (61→30+1).
- **Timeout:** sensor3 never acks, others give 50, 60, 70 → sample_req held 16 cycles, height=65, fault=0100. Ack on cycle 16 instead → no fault.
- **Extremes:** readings 255, 255, 255, 254 → 255. All zeros → height=0, height_valid still pulses.
- **Control:** `start` mid-scan is ignored. A stray ack in SETTLE is ignored. `rst_n` low during REQ → `sample_req`=0 and IDLE immediately; the next scan completes normally.
- **Back-to-back:** `start` held high → consecutive scans every 22 cycles, `height_valid` exactly one cycle each.
